// File: rtl/genshin_cmd_arbiter_if.sv
// Command-source and UART handshake bundle for genshin_cmd_arbiter.
// The arbiter takes the slave side; sources and the UART take the master side.
interface genshin_cmd_arbiter_if #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 8
);
  logic [NUM_SRC*DATA_W-1:0] src_bits;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [DATA_W-1:0]         tx_bits;
  logic                      tx_ready;
  logic [DATA_W-1:0]         rx_bits;
  logic                      rx_valid;

  modport master (
    output src_bits, src_valid, tx_ready, rx_bits, rx_valid,
    input  src_ready, tx_bits
  );

  modport slave (
    input  src_bits, src_valid, tx_ready, rx_bits, rx_valid,
    output src_ready, tx_bits
  );
endinterface

// File: rtl/genshin_cmd_arbiter.sv
// Mode-selected command arbiter: buffers bytes from the chosen source and feeds them to the UART.
// Optional TX watchdog (TIMEOUT_CYC, timeout flag) is built only when GK_TX_TIMEOUT_EN is defined.
module genshin_cmd_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
`ifdef GK_TX_TIMEOUT_EN
  parameter int TIMEOUT_CYC = 4096,
`endif
  parameter logic [DATA_W-1:0] IDLE_BYTE = 8'h00,
  localparam int SEL_W = $clog2(NUM_SRC),
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [SEL_W-1:0]     mode_sel,
  genshin_cmd_arbiter_if.slave bus,
  output logic [DATA_W-1:0]    status_bits,
  output logic                 status_valid,
  output logic [CNT_W-1:0]     fifo_count,
  output logic                 overflow,
  output logic                 timeout
);
  localparam int               PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [DATA_W-1:0]  mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [SEL_W-1:0]   mode_r;
  logic [DATA_W-1:0]  tx_bits_r;
  logic [DATA_W-1:0]  status_bits_r;
  logic               status_valid_r;
  logic               overflow_r;
  logic               timeout_s;

  logic               flush_s;
  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;
  logic               force_pop_s;
  logic               stray_s;
  logic               sel_valid_s;
  logic [NUM_SRC-1:0] src_ready_s;
  logic [DATA_W-1:0]  push_data_s;
  logic [CNT_W-1:0]   count_after_pop_s;
  logic [CNT_W-1:0]   count_next_s;
  logic [PTR_W-1:0]   rd_next_s;
  logic [DATA_W-1:0]  tx_next_s;

  // A mode change seen against the registered copy flushes for exactly one cycle.
  assign flush_s     = (mode_r != mode_sel);
  assign full_s      = (count_r == DEPTH_C);
  assign empty_s     = (count_r == '0);
  assign push_s      = |src_ready_s;
  assign push_data_s = bus.src_bits[mode_sel*DATA_W +: DATA_W];
  assign pop_s       = ~flush_s & ~empty_s & (bus.tx_ready | force_pop_s);

  // Accept decode: only the selected source is ever granted; any other valid is a stray.
  always_comb begin
    src_ready_s = '0;
    stray_s     = 1'b0;
    sel_valid_s = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (SEL_W'(i) == mode_sel) begin
        sel_valid_s    = bus.src_valid[i];
        src_ready_s[i] = bus.src_valid[i] & ~full_s & ~flush_s;
      end else begin
        stray_s = stray_s | bus.src_valid[i];
      end
    end
  end

  // Next occupancy and next head byte; a push into a just-emptied FIFO bypasses storage.
  always_comb begin
    count_after_pop_s = count_r - CNT_W'(pop_s);
    rd_next_s         = rd_ptr_r + PTR_W'(pop_s);
    count_next_s      = '0;
    tx_next_s         = IDLE_BYTE;
    if (flush_s) begin
      count_next_s = '0;
      tx_next_s    = IDLE_BYTE;
    end else begin
      count_next_s = count_after_pop_s + CNT_W'(push_s);
      if (count_next_s == '0) begin
        tx_next_s = IDLE_BYTE;
      end else if (count_after_pop_s == '0) begin
        tx_next_s = push_data_s;
      end else begin
        tx_next_s = mem_r[rd_next_s];
      end
    end
  end

  // Pointers, occupancy, registered mode and the registered head byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      mode_r    <= '0;
      tx_bits_r <= IDLE_BYTE;
    end else begin
      mode_r    <= mode_sel;
      count_r   <= count_next_s;
      tx_bits_r <= tx_next_s;
      if (flush_s) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        rd_ptr_r <= rd_next_s;
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end
      end
    end
  end

  // Byte storage; contents are don't-care until counted in, so no reset is needed.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  // Sticky overflow and the feedback status capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_r     <= 1'b0;
      status_bits_r  <= '0;
      status_valid_r <= 1'b0;
    end else begin
      overflow_r     <= overflow_r | stray_s | (sel_valid_s & full_s);
      status_valid_r <= bus.rx_valid;
      if (bus.rx_valid) begin
        status_bits_r <= bus.rx_bits;
      end
    end
  end

`ifdef GK_TX_TIMEOUT_EN
  localparam int              TO_W      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST_C = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] wait_cnt_r;
  logic            timeout_r;

  assign force_pop_s = ~empty_s & ~bus.tx_ready & (wait_cnt_r == TO_LAST_C);
  assign timeout_s   = timeout_r;

  // Watchdog: counts cycles the head has waited; a lost handshake forces the head out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= '0;
      timeout_r  <= 1'b0;
    end else begin
      if (flush_s | pop_s | empty_s) begin
        wait_cnt_r <= '0;
      end else begin
        wait_cnt_r <= wait_cnt_r + TO_W'(1);
      end
      if (force_pop_s & ~flush_s) begin
        timeout_r <= 1'b1;
      end
    end
  end
`else
  assign force_pop_s = 1'b0;
  assign timeout_s   = 1'b0;
`endif

  assign bus.src_ready = src_ready_s;
  assign bus.tx_bits   = tx_bits_r;
  assign status_bits   = status_bits_r;
  assign status_valid  = status_valid_r;
  assign fifo_count    = count_r;
  assign overflow      = overflow_r;
  assign timeout       = timeout_s;
endmodule

// File: tb/tb_genshin_cmd_arbiter.sv
// Randomised self-checking bench for genshin_cmd_arbiter against a queue-based model.
// Define GK_TX_TIMEOUT_EN on both bench and RTL to exercise the watchdog with a 16-cycle limit.
module tb_genshin_cmd_arbiter;
  localparam int          NUM_SRC = 2;
  localparam int          DATA_W  = 8;
  localparam int          DEPTH   = 4;
  localparam int          SEL_W   = $clog2(NUM_SRC);
  localparam int          CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [7:0]  IDLE    = 8'h00;
`ifdef GK_TX_TIMEOUT_EN
  localparam int          TO_CYC  = 16;
`endif

  logic              clock;
  logic              reset;
  logic [SEL_W-1:0]  mode_sel;
  logic [DATA_W-1:0] status_bits;
  logic              status_valid;
  logic [CNT_W-1:0]  fifo_count;
  logic              overflow;
  logic              timeout;

  genshin_cmd_arbiter_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) bus ();

  genshin_cmd_arbiter #(
    .NUM_SRC(NUM_SRC),
    .DATA_W(DATA_W),
    .FIFO_DEPTH(DEPTH),
`ifdef GK_TX_TIMEOUT_EN
    .TIMEOUT_CYC(TO_CYC),
`endif
    .IDLE_BYTE(IDLE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mode_sel(mode_sel),
    .bus(bus),
    .status_bits(status_bits),
    .status_valid(status_valid),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .timeout(timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain byte queue plus the flags it implies.
  logic [7:0]       q[$];
  logic [SEL_W-1:0] m_mode;
  logic             m_ovf;
  logic [7:0]       m_status;
  logic             m_sv;
  logic             m_to;
  int               m_wd;
  logic [NUM_SRC-1:0] last_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_mode   = '0;
    m_ovf    = 1'b0;
    m_status = 8'h00;
    m_sv     = 1'b0;
    m_to     = 1'b0;
    m_wd     = 0;
  endtask

  function automatic logic [NUM_SRC-1:0] exp_ready();
    logic [NUM_SRC-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (i == int'(mode_sel) && bus.src_valid[i] && q.size() < DEPTH && m_mode == mode_sel)
        r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_step();
    int  sel;
    bit  flush;
    bit  full;
    bit  push;
    bit  pop;
    sel   = int'(mode_sel);
    flush = (m_mode != mode_sel);
    full  = (q.size() == DEPTH);
    push  = bus.src_valid[sel] && !full && !flush;
    for (int i = 0; i < NUM_SRC; i++)
      if (i != sel && bus.src_valid[i]) m_ovf = 1'b1;
    if (bus.src_valid[sel] && full) m_ovf = 1'b1;
    if (flush) begin
      q.delete();
      m_wd = 0;
    end else begin
      pop = bus.tx_ready && q.size() > 0;
`ifdef GK_TX_TIMEOUT_EN
      if (q.size() > 0 && !bus.tx_ready) begin
        if (m_wd == TO_CYC - 1) begin
          pop  = 1'b1;
          m_to = 1'b1;
          m_wd = 0;
        end else begin
          m_wd++;
        end
      end else begin
        m_wd = 0;
      end
`endif
      if (pop) void'(q.pop_front());
      if (push) q.push_back(bus.src_bits[sel*DATA_W +: DATA_W]);
    end
    m_mode = mode_sel;
    if (bus.rx_valid) m_status = bus.rx_bits;
    m_sv = bus.rx_valid;
  endtask

  task automatic compare_regs();
    check("fifo_count", 32'(fifo_count), 32'(q.size()));
    check("tx_bits", 32'(bus.tx_bits), (q.size() > 0) ? 32'(q[0]) : 32'(IDLE));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("status_bits", 32'(status_bits), 32'(m_status));
    check("status_valid", 32'(status_valid), 32'(m_sv));
    check("timeout", 32'(timeout), 32'(m_to));
  endtask

  // One clock cycle: drive at the falling edge, check the accept decode, then the registers.
  task automatic step(input logic [SEL_W-1:0] sel, input logic [NUM_SRC-1:0] vld,
                      input logic [15:0] bits, input logic txr, input logic rxv,
                      input logic [7:0] rxb);
    mode_sel      = sel;
    bus.src_valid = vld;
    bus.src_bits  = bits;
    bus.tx_ready  = txr;
    bus.rx_valid  = rxv;
    bus.rx_bits   = rxb;
    #1;
    last_ready = bus.src_ready;
    check("src_ready", 32'(bus.src_ready), 32'(exp_ready()));
    model_step();
    @(posedge clock);
    #1;
    compare_regs();
    @(negedge clock);
  endtask

  task automatic idle(input logic [SEL_W-1:0] sel);
    step(sel, 2'b00, 16'h0000, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    reset         = 1'b1;
    mode_sel      = '0;
    bus.src_valid = '0;
    bus.src_bits  = '0;
    bus.tx_ready  = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_bits   = '0;
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_tx_bits", 32'(bus.tx_bits), 32'h00);
    check("rst_count", 32'(fifo_count), 32'h0);
    check("rst_src_ready", 32'(bus.src_ready), 32'h0);
    check("rst_flags", {29'h0, overflow, status_valid, timeout}, 32'h0);
    reset = 1'b0;

    // Source 1 sends two bytes, UART drains them.
    idle(1'b1);
    step(1'b1, 2'b10, 16'h2100, 1'b0, 1'b0, 8'h00);
    check("push1_tx", 32'(bus.tx_bits), 32'h21);
    step(1'b1, 2'b10, 16'h2200, 1'b0, 1'b0, 8'h00);
    check("push2_count", 32'(fifo_count), 32'h2);
    step(1'b1, 2'b00, 16'h0000, 1'b1, 1'b0, 8'h00);
    check("pop1_tx", 32'(bus.tx_bits), 32'h22);
    step(1'b1, 2'b00, 16'h0000, 1'b1, 1'b0, 8'h00);
    check("pop2_tx", 32'(bus.tx_bits), 32'h00);
    check("pop2_count", 32'(fifo_count), 32'h0);

    // Source 0 overfills while source 1 is also valid.
    idle(1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 2'b11, {8'hEE, 8'(8'h40 + k)}, 1'b0, 1'b0, 8'h00);
      check("fill_ready", 32'(last_ready), (k < 4) ? 32'h1 : 32'h0);
    end
    check("fill_count", 32'(fifo_count), 32'h4);
    check("fill_overflow", 32'(overflow), 32'h1);
    step(1'b0, 2'b00, 16'h0000, 1'b1, 1'b0, 8'h00);
    check("drain_one_tx", 32'(bus.tx_bits), 32'h41);

    // Switch with three queued: flush, offered push refused.
    step(1'b1, 2'b10, 16'h7700, 1'b0, 1'b0, 8'h00);
    check("flush_ready", 32'(last_ready), 32'h0);
    check("flush_count", 32'(fifo_count), 32'h0);
    check("flush_tx", 32'(bus.tx_bits), 32'h00);
    step(1'b1, 2'b10, 16'h7700, 1'b0, 1'b0, 8'h00);
    check("post_flush_tx", 32'(bus.tx_bits), 32'h77);
    step(1'b1, 2'b00, 16'h0000, 1'b1, 1'b0, 8'h00);

    // Feedback capture.
    step(1'b1, 2'b00, 16'h0000, 1'b0, 1'b1, 8'h5A);
    check("rx_5a_bits", 32'(status_bits), 32'h5A);
    check("rx_5a_valid", 32'(status_valid), 32'h1);
    step(1'b1, 2'b00, 16'h0000, 1'b0, 1'b1, 8'h01);
    step(1'b1, 2'b00, 16'h0000, 1'b0, 1'b1, 8'h02);
    check("rx_b2b_valid", 32'(status_valid), 32'h1);
    check("rx_b2b_bits", 32'(status_bits), 32'h02);
    idle(1'b1);
    check("rx_pulse_end", 32'(status_valid), 32'h0);

`ifdef GK_TX_TIMEOUT_EN
    step(1'b1, 2'b10, 16'h3300, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 15; k++) idle(1'b1);
    check("wd_hold_count", 32'(fifo_count), 32'h1);
    check("wd_hold_timeout", 32'(timeout), 32'h0);
    idle(1'b1);
    check("wd_fire_count", 32'(fifo_count), 32'h0);
    check("wd_fire_timeout", 32'(timeout), 32'h1);
    check("wd_fire_tx", 32'(bus.tx_bits), 32'h00);
`endif

    // Asynchronous reset mid-transfer.
    step(1'b1, 2'b10, 16'h9900, 1'b0, 1'b0, 8'h00);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_tx", 32'(bus.tx_bits), 32'h00);
    check("async_rst_count", 32'(fifo_count), 32'h0);
    model_reset();
    @(negedge clock);
    mode_sel      = '0;
    bus.src_valid = '0;
    bus.tx_ready  = 1'b0;
    bus.rx_valid  = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // Randomised traffic, checked every cycle against the model.
    begin
      logic [SEL_W-1:0]   sel;
      logic [NUM_SRC-1:0] vld;
      sel = '0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 49) == 0) sel = SEL_W'($urandom_range(0, NUM_SRC - 1));
        vld = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (i == int'(sel)) vld[i] = ($urandom_range(0, 9) < 6);
          else                vld[i] = ($urandom_range(0, 199) == 0);
        end
        step(sel, vld, 16'($urandom), ($urandom_range(0, 99) < 35),
             ($urandom_range(0, 3) == 0), 8'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
